// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the radix-8 Booth recoder.
//   DIGIT_SPAN   : multiplier bits consumed per radix-8 digit (3).
//   booth_sel_t  : one-hot-or-zero select bundle {s, d, t, q, n} for one digit.
//   booth_groups : number of radix-8 digits needed for a given operand width.
package booth_pkg;

    localparam int unsigned DIGIT_SPAN = 3;

    typedef struct packed {
        logic s;   // |digit| == 1
        logic d;   // |digit| == 2
        logic t;   // |digit| == 3
        logic q;   // |digit| == 4
        logic n;   // digit sign (top bit of the 4-bit window)
    } booth_sel_t;

    function automatic int unsigned booth_groups(input int unsigned width);
        return (width + DIGIT_SPAN) / DIGIT_SPAN;
    endfunction

endpackage

// File: rtl/booth_r8_enc_pipe_if.sv
// booth_r8_enc_pipe_if: operand/result bundle for booth_r8_enc_pipe.
//   Input side : in_valid, in_ready, in_signed, in_mx[WIDTH], in_mc[WIDTH]
//   Output side: out_valid, out_ready, out_s/d/t/q/n[GROUPS], out_x3[WIDTH+2],
//                out_signed, and out_nz_cnt when BOOTH_NZCNT_EN is defined.
//   slave modport  : recoder view.
//   master modport : producer/consumer view (operand staging + PP generator).
interface booth_r8_enc_pipe_if
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);

    localparam int unsigned GROUPS = booth_groups(WIDTH);

    logic              in_valid;
    logic              in_ready;
    logic              in_signed;
    logic [WIDTH-1:0]  in_mx;
    logic [WIDTH-1:0]  in_mc;
    logic              out_valid;
    logic              out_ready;
    logic [GROUPS-1:0] out_s;
    logic [GROUPS-1:0] out_d;
    logic [GROUPS-1:0] out_t;
    logic [GROUPS-1:0] out_q;
    logic [GROUPS-1:0] out_n;
    logic [WIDTH+1:0]  out_x3;
    logic              out_signed;
`ifdef BOOTH_NZCNT_EN
    localparam int unsigned NZ_W = $clog2(GROUPS + 1);
    logic [NZ_W-1:0]   out_nz_cnt;
`endif

    modport slave (
        input  in_valid, in_signed, in_mx, in_mc, out_ready,
        output in_ready, out_valid, out_s, out_d, out_t, out_q, out_n,
               out_x3, out_signed
`ifdef BOOTH_NZCNT_EN
        , output out_nz_cnt
`endif
    );

    modport master (
        output in_valid, in_signed, in_mx, in_mc, out_ready,
        input  in_ready, out_valid, out_s, out_d, out_t, out_q, out_n,
               out_x3, out_signed
`ifdef BOOTH_NZCNT_EN
        , input out_nz_cnt
`endif
    );

endinterface

// File: rtl/booth_r8_digit.sv
// booth_r8_digit: combinational radix-8 Booth digit recoder.
//   grp_bits[3:0] : {m[3i+2], m[3i+1], m[3i], m[3i-1]} window of the multiplier.
//   sel           : one-hot-or-zero magnitude selects plus sign n = grp_bits[3].
module booth_r8_digit
    import booth_pkg::*;
(
    input  logic [3:0] grp_bits,
    output booth_sel_t sel
);

    logic w0;
    logic w1;
    logic w2;

    always_comb begin
        w0    = grp_bits[0] ^ grp_bits[1];
        w1    = grp_bits[1] ^ grp_bits[2];
        w2    = grp_bits[2] ^ grp_bits[3];
        sel   = '0;
        sel.s = w0 & ~w2;
        sel.d = w1 & ~w0;
        sel.t = w2 & w0;
        sel.q = w2 & ~w0 & ~w1;
        // 1111 yields a zero digit with n set; consumers ignore n when no magnitude is selected.
        sel.n = grp_bits[3];
    end

endmodule

// File: rtl/booth_r8_enc_pipe.sv
// booth_r8_enc_pipe: two-stage pipelined radix-8 Booth recoder with 3X multiple.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset.
//   bus        : booth_r8_enc_pipe_if.slave
//                  in_*  : multiplier mx, multiplicand mc, signed mode (valid/ready)
//                  out_* : per-group s/d/t/q/n selects, x3 = 3*mc (WIDTH+2 bits),
//                          mode echo (valid/ready).
//   S1 registers operands; S2 registers recoded digits and 3X (latency 2).
//   Optional: BOOTH_NZCNT_EN adds out_nz_cnt, the count of nonzero digits.
module booth_r8_enc_pipe
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    booth_r8_enc_pipe_if.slave bus
);

    localparam int unsigned GROUPS = booth_groups(WIDTH);
    // Bit 0 holds m[-1]; the window of the last group ends at bit DIGIT_SPAN*GROUPS.
    localparam int unsigned EXT_W  = DIGIT_SPAN * GROUPS + 1;
    localparam int unsigned X3_W   = WIDTH + 2;
`ifdef BOOTH_NZCNT_EN
    localparam int unsigned NZ_W   = $clog2(GROUPS + 1);
`endif

    logic adv1;
    logic adv2;

    logic              s1_valid_d,  s1_valid_q;
    logic              s1_signed_d, s1_signed_q;
    logic [WIDTH-1:0]  s1_mx_d,     s1_mx_q;
    logic [WIDTH-1:0]  s1_mc_d,     s1_mc_q;

    logic              s2_valid_d,  s2_valid_q;
    logic              s2_signed_d, s2_signed_q;
    logic [GROUPS-1:0] s2_s_d,      s2_s_q;
    logic [GROUPS-1:0] s2_d_d,      s2_d_q;
    logic [GROUPS-1:0] s2_t_d,      s2_t_q;
    logic [GROUPS-1:0] s2_q_d,      s2_q_q;
    logic [GROUPS-1:0] s2_n_d,      s2_n_q;
    logic [X3_W-1:0]   s2_x3_d,     s2_x3_q;
`ifdef BOOTH_NZCNT_EN
    logic [NZ_W-1:0]   s2_nz_d,     s2_nz_q;
    logic [NZ_W-1:0]   nz_c;
`endif

    logic              ext_bit;
    logic [EXT_W-1:0]  m_ext;
    booth_sel_t        sel [GROUPS];
    logic [GROUPS-1:0] sel_s, sel_d, sel_t, sel_q, sel_n;
    logic [X3_W-1:0]   xe;
    logic [X3_W-1:0]   x3_c;

    // Handshake: S2 frees when empty or draining; S1 frees when empty or moving into S2.
    always_comb begin
        adv2         = ~s2_valid_q | bus.out_ready;
        adv1         = ~s1_valid_q | adv2;
        bus.in_ready = adv1;
    end

    // Extended multiplier: m[-1] = 0, bits above the MSB follow the mode.
    always_comb begin
        ext_bit         = s1_signed_q & s1_mx_q[WIDTH-1];
        m_ext           = {EXT_W{ext_bit}};
        m_ext[0]        = 1'b0;
        m_ext[WIDTH:1]  = s1_mx_q;
    end

    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_digit
        booth_r8_digit u_digit (
            .grp_bits (m_ext[DIGIT_SPAN*gi +: 4]),
            .sel      (sel[gi])
        );
    end

    always_comb begin
        sel_s = '0;
        sel_d = '0;
        sel_t = '0;
        sel_q = '0;
        sel_n = '0;
        for (int unsigned i = 0; i < GROUPS; i++) begin
            sel_s[i] = sel[i].s;
            sel_d[i] = sel[i].d;
            sel_t[i] = sel[i].t;
            sel_q[i] = sel[i].q;
            sel_n[i] = sel[i].n;
        end
    end

    // Two guard bits make 3*mc exact in both modes.
    always_comb begin
        xe   = s1_signed_q ? {{2{s1_mc_q[WIDTH-1]}}, s1_mc_q} : {2'b00, s1_mc_q};
        x3_c = (xe << 1) + xe;
    end

`ifdef BOOTH_NZCNT_EN
    always_comb begin
        nz_c = '0;
        for (int unsigned i = 0; i < GROUPS; i++) begin
            nz_c = nz_c + NZ_W'(sel_s[i] | sel_d[i] | sel_t[i] | sel_q[i]);
        end
    end
`endif

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_signed_d = s1_signed_q;
        s1_mx_d     = s1_mx_q;
        s1_mc_d     = s1_mc_q;
        if (adv1) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_signed_d = bus.in_signed;
                s1_mx_d     = bus.in_mx;
                s1_mc_d     = bus.in_mc;
            end
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_signed_d = s2_signed_q;
        s2_s_d      = s2_s_q;
        s2_d_d      = s2_d_q;
        s2_t_d      = s2_t_q;
        s2_q_d      = s2_q_q;
        s2_n_d      = s2_n_q;
        s2_x3_d     = s2_x3_q;
`ifdef BOOTH_NZCNT_EN
        s2_nz_d     = s2_nz_q;
`endif
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_signed_d = s1_signed_q;
                s2_s_d      = sel_s;
                s2_d_d      = sel_d;
                s2_t_d      = sel_t;
                s2_q_d      = sel_q;
                s2_n_d      = sel_n;
                s2_x3_d     = x3_c;
`ifdef BOOTH_NZCNT_EN
                s2_nz_d     = nz_c;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_mx_q     <= '0;
            s1_mc_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_signed_q <= 1'b0;
            s2_s_q      <= '0;
            s2_d_q      <= '0;
            s2_t_q      <= '0;
            s2_q_q      <= '0;
            s2_n_q      <= '0;
            s2_x3_q     <= '0;
`ifdef BOOTH_NZCNT_EN
            s2_nz_q     <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_signed_q <= s1_signed_d;
            s1_mx_q     <= s1_mx_d;
            s1_mc_q     <= s1_mc_d;
            s2_valid_q  <= s2_valid_d;
            s2_signed_q <= s2_signed_d;
            s2_s_q      <= s2_s_d;
            s2_d_q      <= s2_d_d;
            s2_t_q      <= s2_t_d;
            s2_q_q      <= s2_q_d;
            s2_n_q      <= s2_n_d;
            s2_x3_q     <= s2_x3_d;
`ifdef BOOTH_NZCNT_EN
            s2_nz_q     <= s2_nz_d;
`endif
        end
    end

    always_comb begin
        bus.out_valid  = s2_valid_q;
        bus.out_signed = s2_signed_q;
        bus.out_s      = s2_s_q;
        bus.out_d      = s2_d_q;
        bus.out_t      = s2_t_q;
        bus.out_q      = s2_q_q;
        bus.out_n      = s2_n_q;
        bus.out_x3     = s2_x3_q;
`ifdef BOOTH_NZCNT_EN
        bus.out_nz_cnt = s2_nz_q;
`endif
    end

endmodule

// File: tb/tb_booth_r8_enc_pipe.sv
// tb_booth_r8_enc_pipe: self-checking bench for booth_r8_enc_pipe at WIDTH 8/16/32.
// Directed checks run on the 32-bit instance; the random phase drives all three.
// Optional BOOTH_NZCNT_EN also checks out_nz_cnt.
module tb_booth_r8_enc_pipe;

    localparam int RAND_CYCLES = 10000;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    booth_r8_enc_pipe_if #(.WIDTH(8))  if8  ();
    booth_r8_enc_pipe_if #(.WIDTH(16)) if16 ();
    booth_r8_enc_pipe_if #(.WIDTH(32)) if32 ();

    booth_r8_enc_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    booth_r8_enc_pipe #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    booth_r8_enc_pipe #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got time limit, required $finish)");
        $fatal(1);
    end

    typedef struct {
        logic        sg;
        logic [31:0] mx;
        logic [31:0] mc;
        logic [10:0] s, d, t, q, n;
        logic [33:0] x3;
    } dvec_t;

    // Scoreboard per width instance: small circular buffers.
    logic [31:0] sb_mx [3][8];
    logic [31:0] sb_mc [3][8];
    logic        sb_sg [3][8];
    int          wr_p  [3];
    int          rd_p  [3];
    int          widths[3];

    // ---------------- reference model helpers ----------------
    function automatic logic mbit(input logic [31:0] mx, input int w, input logic sg, input int k);
        if (k < 0) return 1'b0;
        if (k >= w) return sg & mx[w-1];
        return mx[k];
    endfunction

    function automatic longint val_of(input logic [31:0] x, input int w, input logic sg);
        longint v;
        v = longint'({32'd0, x}) & ((longint'(1) << w) - 1);
        if (sg && x[w-1]) v = v - (longint'(1) << w);
        return v;
    endfunction

    task automatic ref_model(input int w, input logic [31:0] mx, input logic [31:0] mc,
                             input logic sg,
                             output logic [10:0] es, output logic [10:0] ed,
                             output logic [10:0] et, output logic [10:0] eq,
                             output logic [10:0] en, output logic [33:0] ex3);
        int g;
        int dg;
        int mag;
        longint xv;
        g  = (w + 3) / 3;
        es = '0; ed = '0; et = '0; eq = '0; en = '0;
        for (int i = 0; i < g; i++) begin
            dg = -4 * int'(mbit(mx, w, sg, 3*i+2)) + 2 * int'(mbit(mx, w, sg, 3*i+1))
                 + int'(mbit(mx, w, sg, 3*i)) + int'(mbit(mx, w, sg, 3*i-1));
            mag = (dg < 0) ? -dg : dg;
            es[i] = (mag == 1);
            ed[i] = (mag == 2);
            et[i] = (mag == 3);
            eq[i] = (mag == 4);
            en[i] = mbit(mx, w, sg, 3*i+2);
        end
        xv  = val_of(mc, w, sg);
        ex3 = 34'((3 * xv) & ((longint'(1) << (w + 2)) - 1));
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_8080;
            3:       return 32'h7FFF_7F7F;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic sg,
                         input logic [31:0] mx, input logic [31:0] mc, input logic ordy);
        case (sel)
            0: begin
                if8.in_valid = v;  if8.in_signed = sg;
                if8.in_mx = mx[7:0]; if8.in_mc = mc[7:0]; if8.out_ready = ordy;
            end
            1: begin
                if16.in_valid = v; if16.in_signed = sg;
                if16.in_mx = mx[15:0]; if16.in_mc = mc[15:0]; if16.out_ready = ordy;
            end
            default: begin
                if32.in_valid = v; if32.in_signed = sg;
                if32.in_mx = mx; if32.in_mc = mc; if32.out_ready = ordy;
            end
        endcase
    endtask

    task automatic get_obs(input int sel,
                           output logic iv, output logic ir, output logic ov, output logic ordy,
                           output logic osg, output logic [31:0] imx, output logic [31:0] imc,
                           output logic isg,
                           output logic [10:0] os, output logic [10:0] od, output logic [10:0] ot,
                           output logic [10:0] oq, output logic [10:0] on,
                           output logic [33:0] ox3, output logic [3:0] onz);
        onz = '0;
        case (sel)
            0: begin
                iv = if8.in_valid; ir = if8.in_ready; ov = if8.out_valid; ordy = if8.out_ready;
                osg = if8.out_signed; imx = 32'(if8.in_mx); imc = 32'(if8.in_mc); isg = if8.in_signed;
                os = 11'(if8.out_s); od = 11'(if8.out_d); ot = 11'(if8.out_t);
                oq = 11'(if8.out_q); on = 11'(if8.out_n); ox3 = 34'(if8.out_x3);
`ifdef BOOTH_NZCNT_EN
                onz = 4'(if8.out_nz_cnt);
`endif
            end
            1: begin
                iv = if16.in_valid; ir = if16.in_ready; ov = if16.out_valid; ordy = if16.out_ready;
                osg = if16.out_signed; imx = 32'(if16.in_mx); imc = 32'(if16.in_mc); isg = if16.in_signed;
                os = 11'(if16.out_s); od = 11'(if16.out_d); ot = 11'(if16.out_t);
                oq = 11'(if16.out_q); on = 11'(if16.out_n); ox3 = 34'(if16.out_x3);
`ifdef BOOTH_NZCNT_EN
                onz = 4'(if16.out_nz_cnt);
`endif
            end
            default: begin
                iv = if32.in_valid; ir = if32.in_ready; ov = if32.out_valid; ordy = if32.out_ready;
                osg = if32.out_signed; imx = if32.in_mx; imc = if32.in_mc; isg = if32.in_signed;
                os = 11'(if32.out_s); od = 11'(if32.out_d); ot = 11'(if32.out_t);
                oq = 11'(if32.out_q); on = 11'(if32.out_n); ox3 = if32.out_x3;
`ifdef BOOTH_NZCNT_EN
                onz = 4'(if32.out_nz_cnt);
`endif
            end
        endcase
    endtask

    task automatic idle_all();
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (if32.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %0b expected 0", if32.out_valid);
        end
        total++;
        if ({if32.out_s, if32.out_n, if32.out_x3, if32.out_signed} !== '0) begin
            bad++; $display("FAIL reset_out_data: got s=%h n=%h x3=%h expected all 0",
                            if32.out_s, if32.out_n, if32.out_x3);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (if32.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %0b expected 1", if32.in_ready);
        end
    endtask

    task automatic test_directed();
        dvec_t dv [6];
        dv[0] = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFF, 11'h003, 11'h0, 11'h0, 11'h0,   11'h001, 34'h2_FFFF_FFFD};
        dv[1] = '{1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 11'h001, 11'h0, 11'h0, 11'h0,   11'h7FF, 34'h1_7FFF_FFFD};
        dv[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 11'h001, 11'h0, 11'h0, 11'h400, 11'h3FF, 34'h0};
        dv[3] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 11'h0,   11'h0, 11'h001, 11'h0, 11'h0,   34'h0_0000_000F};
        dv[4] = '{1'b1, 32'h0000_0000, 32'h8000_0000, 11'h0,   11'h0, 11'h0, 11'h0,   11'h0,   34'h2_8000_0000};
        dv[5] = '{1'b1, 32'h0000_0007, 32'h0000_0001, 11'h003, 11'h0, 11'h0, 11'h0,   11'h001, 34'h0_0000_0003};
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            drive(2, 1'b1, dv[k].sg, dv[k].mx, dv[k].mc, 1'b1);
            @(negedge clk);
            total++;
            if (if32.in_ready !== 1'b1) begin
                bad++; $display("FAIL dir%0d_in_ready: got %0b expected 1", k, if32.in_ready);
            end
            @(posedge clk); #1;
            if32.in_valid = 1'b0;
            @(negedge clk);
            total++;
            if (if32.out_valid !== 1'b0) begin
                bad++; $display("FAIL dir%0d_latency_early: out_valid got %0b expected 0", k, if32.out_valid);
            end
            @(negedge clk);
            total++;
            if (if32.out_valid !== 1'b1) begin
                bad++; $display("FAIL dir%0d_latency: out_valid got %0b expected 1", k, if32.out_valid);
            end
            total++;
            if ({if32.out_s, if32.out_d, if32.out_t, if32.out_q, if32.out_n} !==
                {dv[k].s, dv[k].d, dv[k].t, dv[k].q, dv[k].n}) begin
                bad++;
                $display("FAIL dir%0d_selects: got s=%h d=%h t=%h q=%h n=%h expected s=%h d=%h t=%h q=%h n=%h",
                         k, if32.out_s, if32.out_d, if32.out_t, if32.out_q, if32.out_n,
                         dv[k].s, dv[k].d, dv[k].t, dv[k].q, dv[k].n);
            end
            total++;
            if (if32.out_x3 !== dv[k].x3) begin
                bad++; $display("FAIL dir%0d_x3: got %h expected %h", k, if32.out_x3, dv[k].x3);
            end
            total++;
            if (if32.out_signed !== dv[k].sg) begin
                bad++; $display("FAIL dir%0d_signed: got %0b expected %0b", k, if32.out_signed, dv[k].sg);
            end
`ifdef BOOTH_NZCNT_EN
            total++;
            if (32'(if32.out_nz_cnt) !== 32'($countones(dv[k].s | dv[k].d | dv[k].t | dv[k].q))) begin
                bad++; $display("FAIL dir%0d_nz_cnt: got %0d expected %0d", k, if32.out_nz_cnt,
                                $countones(dv[k].s | dv[k].d | dv[k].t | dv[k].q));
            end
`endif
        end
        @(posedge clk); #1;
        idle_all();
    endtask

    task automatic test_back_to_back();
        logic [31:0] mcs [3];
        logic [33:0] held;
        int sent;
        int got;
        int last_cyc;
        mcs[0] = 32'h11; mcs[1] = 32'h22; mcs[2] = 32'h33;
        sent = 0; got = 0; last_cyc = 0; held = '0;
        for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
            @(posedge clk); #1;
            if (sent < 3) drive(2, 1'b1, 1'b0, 32'h0, mcs[sent], cyc >= 6);
            else          drive(2, 1'b0, 1'b0, 32'h0, 32'h0,    cyc >= 6);
            @(negedge clk);
            if (cyc == 4) begin
                total++;
                if (if32.in_ready !== 1'b0 || if32.out_valid !== 1'b1) begin
                    bad++; $display("FAIL b2b_stall_state: got in_ready=%0b out_valid=%0b expected 0/1",
                                    if32.in_ready, if32.out_valid);
                end
                held = if32.out_x3;
            end
            if (cyc == 5) begin
                total++;
                if (if32.out_x3 !== held || held !== 34'h33) begin
                    bad++; $display("FAIL b2b_stall_hold: got %h (earlier %h) expected 33", if32.out_x3, held);
                end
            end
            if (if32.out_valid && if32.out_ready) begin
                total++;
                if (if32.out_x3 !== 34'(3 * mcs[got])) begin
                    bad++; $display("FAIL b2b_order%0d: got x3=%h expected %h", got, if32.out_x3, 34'(3 * mcs[got]));
                end
                if (got > 0) begin
                    total++;
                    if (cyc != last_cyc + 1) begin
                        bad++; $display("FAIL b2b_consecutive%0d: got cycle %0d expected %0d", got, cyc, last_cyc + 1);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            if (if32.in_valid && if32.in_ready) sent++;
        end
        total++;
        if (got != 3) begin
            bad++; $display("FAIL b2b_timeout: got %0d bundles expected 3", got);
        end
        @(posedge clk); #1;
        idle_all();
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b0, 32'h7, 32'h5, 1'b0);
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b0, 32'h7, 32'h6, 1'b0);
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (if32.out_valid !== 1'b1 || if32.out_s !== 11'h003) begin
            bad++; $display("FAIL midrst_preload: got out_valid=%0b s=%h expected 1/003", if32.out_valid, if32.out_s);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (if32.out_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_async_valid: got %0b expected 0", if32.out_valid);
        end
        total++;
        if ({if32.out_s, if32.out_n, if32.out_x3} !== '0) begin
            bad++; $display("FAIL midrst_async_data: got s=%h n=%h x3=%h expected 0",
                            if32.out_s, if32.out_n, if32.out_x3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        if32.out_ready = 1'b1;
        #1;
        total++;
        if (if32.in_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_in_ready: got %0b expected 1", if32.in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (if32.out_valid !== 1'b0) begin
                bad++; $display("FAIL midrst_stale%0d: out_valid got %0b expected 0", c, if32.out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic iv, ir, ov, ordy, osg, isg;
        logic [31:0] imx, imc, e_mx, e_mc;
        logic e_sg;
        logic [10:0] os, od, ot, oq, on, es, ed, et, eq, en;
        logic [33:0] ox3, ex3;
        logic [3:0] onz;
        int w;
        int g;
        int mag;
        longint acc;
        for (int s = 0; s < 3; s++) begin
            wr_p[s] = 0; rd_p[s] = 0;
        end
        for (int cyc = 0; cyc < RAND_CYCLES + 6; cyc++) begin
            @(posedge clk); #1;
            for (int s = 0; s < 3; s++) begin
                if (cyc < RAND_CYCLES)
                    drive(s, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          pick_val(), pick_val(), $urandom_range(0, 3) != 0);
                else
                    drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            end
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                get_obs(s, iv, ir, ov, ordy, osg, imx, imc, isg, os, od, ot, oq, on, ox3, onz);
                w = widths[s];
                g = (w + 3) / 3;
                if (ov && ordy) begin
                    if (rd_p[s] == wr_p[s]) begin
                        total++; bad++;
                        $display("FAIL rand_w%0d_spurious: got out_valid=1 expected no pending bundle", w);
                    end else begin
                        e_mx = sb_mx[s][rd_p[s] % 8];
                        e_mc = sb_mc[s][rd_p[s] % 8];
                        e_sg = sb_sg[s][rd_p[s] % 8];
                        rd_p[s]++;
                        ref_model(w, e_mx, e_mc, e_sg, es, ed, et, eq, en, ex3);
                        total++;
                        if ({os, od, ot, oq, on} !== {es, ed, et, eq, en}) begin
                            bad++;
                            $display("FAIL rand_w%0d_selects mx=%h sg=%0b: got s=%h d=%h t=%h q=%h n=%h expected s=%h d=%h t=%h q=%h n=%h",
                                     w, e_mx, e_sg, os, od, ot, oq, on, es, ed, et, eq, en);
                        end
                        acc = 0;
                        for (int i = 0; i < g; i++) begin
                            mag = int'(os[i]) + 2 * int'(od[i]) + 3 * int'(ot[i]) + 4 * int'(oq[i]);
                            acc = acc + longint'(on[i] ? -mag : mag) * (longint'(1) << (3 * i));
                        end
                        total++;
                        if (acc != val_of(e_mx, w, e_sg)) begin
                            bad++; $display("FAIL rand_w%0d_digit_sum mx=%h: got %0d expected %0d",
                                            w, e_mx, acc, val_of(e_mx, w, e_sg));
                        end
                        total++;
                        if (ox3 !== ex3) begin
                            bad++; $display("FAIL rand_w%0d_x3 mc=%h sg=%0b: got %h expected %h", w, e_mc, e_sg, ox3, ex3);
                        end
                        total++;
                        if (osg !== e_sg) begin
                            bad++; $display("FAIL rand_w%0d_signed: got %0b expected %0b", w, osg, e_sg);
                        end
`ifdef BOOTH_NZCNT_EN
                        total++;
                        if (32'(onz) !== 32'($countones(es | ed | et | eq))) begin
                            bad++; $display("FAIL rand_w%0d_nz_cnt: got %0d expected %0d", w, onz, $countones(es | ed | et | eq));
                        end
`endif
                    end
                end
                if (iv && ir) begin
                    sb_mx[s][wr_p[s] % 8] = imx;
                    sb_mc[s][wr_p[s] % 8] = imc;
                    sb_sg[s][wr_p[s] % 8] = isg;
                    wr_p[s]++;
                end
            end
        end
        for (int s = 0; s < 3; s++) begin
            total++;
            if (wr_p[s] != rd_p[s]) begin
                bad++; $display("FAIL rand_w%0d_drain: got %0d outstanding expected 0", widths[s], wr_p[s] - rd_p[s]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        widths[0] = 8; widths[1] = 16; widths[2] = 32;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_r8_enc_pipe.md
Name: booth_r8_enc_pipe

Overview:
- Parametrised, pipelined radix-8 Booth recoder for the MAC datapath.
- Takes a multiplier and a multiplicand with a per-transaction signed/unsigned mode, and produces one-hot per-group selects (single/double/triple/quad/neg).
- Also produces the precomputed hard multiple 3X of the multiplicand.
- Sits between operand staging and the partial-product generator; uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand width in bits (>=4).
- GROUPS, (WIDTH+3)/3 (integer division), number of radix-8 digits. Derived; must not be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block accepts input this cycle.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_mx  in  WIDTH  multiplier (recoded operand).
- in_mc  in  WIDTH  multiplicand (source of 3X).
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_s  out  GROUPS  digit magnitude 1.
- out_d  out  GROUPS  digit magnitude 2.
- out_t  out  GROUPS  digit magnitude 3.
- out_q  out  GROUPS  digit magnitude 4.
- out_n  out  GROUPS  digit negative (the digit's top bit).
- out_x3  out  WIDTH+2  3*mc, sign- or zero-extended per mode.
- out_signed  out  1  mode carried alongside the bundle.

Behaviour:
- Two-stage pipeline:
  - S1 registers the operands and mode.
  - S2 registers the recoded digits and 3X.
  - Latency is 2 cycles from input handshake to out_valid when there is no stall.
- Handshake rules:
  - Input transfer occurs when in_valid & in_ready; output transfer occurs when out_valid & out_ready.
  - adv2 = ~s2_valid | out_ready; adv1 = ~s1_valid | adv2.
  - in_ready = adv1. This is combinational, and full throughput of 1 per cycle is sustained while out_ready = 1.
  - While stalled, all S1/S2 data and valids hold. out_* data must not change while out_valid & ~out_ready.
- Extended multiplier: m[-1] = 0; for k >= WIDTH, m[k] = in_signed ? m[WIDTH-1] : 0.
- Group i uses bits b3..b0 = {m[3i+2], m[3i+1], m[3i], m[3i-1]}.
  - Digit = -4*b3 + 2*b2 + b1 + b0, in the range -4..+4.
  - Select equations (w0 = b0^b1, w1 = b1^b2, w2 = b2^b3):
    - s = w0 & ~w2
    - d = w1 & ~w0
    - t = w2 & w0
    - q = w2 & ~w0 & ~w1
    - n = b3
  - At most one of s/d/t/q is set; digit 0 gives all four 0.
  - Zero digits built from 1111 have n = 1. Downstream tolerates this.
- Sum over i of digit_i * 8^i equals mx interpreted per in_signed. This must hold for every WIDTH and both modes.
- 3X: xe = in_signed ? sign-extend(mc, WIDTH+2) : zero-extend(mc, WIDTH+2); x3 = (xe<<1) + xe, truncated to WIDTH+2. This never overflows.
- Recode and 3X are computed combinationally from S1 and registered into S2.
- Reset: all valids are 0 and all out_* are 0, asynchronously. Reset mid-operation discards both in-flight bundles with no partial output. in_ready = 1 in the first cycle after deassertion.
- Simultaneous events:
  - An accept into S1 while S1 moves to S2 in the same cycle is legal and loses no data.
  - An S2 drain plus refill in the same cycle is legal.

Optional Feature:
- Macro: BOOTH_NZCNT_EN.
- When defined:
  - Adds output port out_nz_cnt, width $clog2(GROUPS+1).
  - out_nz_cnt is the number of groups with a nonzero digit (s|d|t|q).
  - It is registered in S2 with the same timing and stall rules as the other outputs, and resets to 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package booth_pkg:
  - Function to compute GROUPS from WIDTH.
  - Struct/typedef for a per-group select bundle {s, d, t, q, n}.
  - Constant for digit span 3.
- Sub-module booth_r8_digit:
  - Combinational 4-bit to select bundle.
  - Instantiated GROUPS times via a generate loop over the extended multiplier.

Test Plan:
- WIDTH=32, unsigned, mx=0x00000007 -> 2 cycles later, group0 s=1 n=1 (-1), group1 s=1 n=0 (+1), groups 2..10 all-zero selects with n=0.
- Signed mx=0xFFFFFFFF -> group0 = -1; groups 1..10 zero digits with n=1. Unsigned mx=0xFFFFFFFF -> group0 = -1, groups 1..9 zero with n=1, group10 q=1 n=0 (+4).
- Unsigned mx=0x00000003 -> group0 t=1 n=0. Signed mc=0x7FFFFFFF -> out_x3=0x17FFFFFFD. Signed mc=0x80000000 -> out_x3=0x280000000. Unsigned mc=0xFFFFFFFF -> out_x3=0x2FFFFFFFD.
- Back-to-back 3 inputs with out_ready held 0 after the first out_valid -> in_ready falls after S1 and S2 fill, outputs are stable, and releasing out_ready delivers all 3 in order on consecutive cycles.
- Assert rst_n low with 2 bundles in flight -> out_valid=0 and all outputs 0 immediately (async); after release, no stale bundle appears.
- Random 10k vectors, WIDTH in {8, 16, 32}, both modes -> scoreboard checks sum(digit_i*8^i)=mx, one-hot-or-zero selects, and x3=3*mc. With BOOTH_NZCNT_EN, out_nz_cnt for mx=0x00000007 equals 2.
